// File: rtl/opti_in_stage.sv
// Input conditioning and pacing stage ahead of the SOS filter: buffers samples in a FIFO,
// applies rounded headroom shift with saturation, and issues them as paced single-cycle pulses.
module opti_in_stage #(
  parameter int DEPTH     = 8,
  parameter int ISSUE_GAP = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [23:0]              s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [1:0]               shift,
  input  logic                     en,
  input  logic                     clear_sat,
  output logic [23:0]              data_out,
  output logic                     data_valid_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     sat_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GW-1:0]     GAP_LOAD = GW'(ISSUE_GAP - 1);
  localparam logic [AW:0]       FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic signed [24:0] SAT_MAX = 25'sd4194303;
  localparam logic signed [24:0] SAT_MIN = -25'sd4194304;

  logic [23:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [GW-1:0] r_gap;
  logic [23:0]   r_data_out;
  logic          r_valid;
  logic          r_sat;

  logic signed [24:0] w_ext;
  logic signed [24:0] w_round;
  logic signed [24:0] w_sum;
  logic signed [24:0] w_t;
  logic               w_sat_hi;
  logic               w_sat_lo;
  logic [23:0]        w_cond;
  logic               w_push;
  logic               w_empty;
  logic               w_issue;

  // 25-bit intermediate so the rounding add cannot overflow before the shift.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_round = '0;
    case (shift)
      2'd1:    w_round = 25'sd1;
      2'd2:    w_round = 25'sd2;
      2'd3:    w_round = 25'sd4;
      default: w_round = '0;
    endcase
    w_ext    = {s_data[23], s_data};
    w_sum    = w_ext + w_round;
    w_t      = w_sum >>> shift;
    w_sat_hi = (w_t > SAT_MAX);
    w_sat_lo = (w_t < SAT_MIN);
    if (w_sat_hi)      w_cond = SAT_MAX[23:0];
    else if (w_sat_lo) w_cond = SAT_MIN[23:0];
    else               w_cond = w_t[23:0];
  end

  assign s_ready = (r_count != FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = s_valid && s_ready;
  assign w_issue = en && !w_empty && (r_gap == '0);

  // NOTE: sample storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cond;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Gap counter keeps running down while en is low, so a late enable issues at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap      <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_issue;
      if (w_issue) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_gap      <= GAP_LOAD;
      end else if (r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  // Set dominates clear when both happen on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (w_push && (w_sat_hi || w_sat_lo)) begin
      r_sat <= 1'b1;
    end else if (clear_sat) begin
      r_sat <= 1'b0;
    end
  end

  assign data_out       = r_data_out;
  assign data_valid_out = r_valid;
  assign fifo_level     = r_count;
  assign sat_flag       = r_sat;

endmodule

// File: tb/tb_opti_in_stage.sv
// Self-checking bench for opti_in_stage: random and directed stimulus against a
// queue-based reference model that derives issue timing from elapsed cycles.
module tb_opti_in_stage;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [23:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [1:0]    shift;
  logic          en;
  logic          clear_sat;
  logic [23:0]   data_out;
  logic          data_valid_out;
  logic [LW-1:0] fifo_level;
  logic          sat_flag;

  opti_in_stage #(.DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .shift          (shift),
    .en             (en),
    .clear_sat      (clear_sat),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .fifo_level     (fifo_level),
    .sat_flag       (sat_flag)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state
  int exp_q[$];
  int m_level;
  int m_last;
  int m_dout;
  bit m_dvo;
  bit m_sat;

  // Observed pulses (value and cycle index)
  int obs_val[$];
  int obs_cyc[$];

  function automatic void cond(input int x, input int sh, output int q, output bit sat);
    int d;
    int n;
    if (sh == 0) begin
      q = x;
    end else begin
      d = 1 << sh;
      n = x + d / 2;
      q = n / d;
      if ((n % d) != 0 && n < 0) q = q - 1;
    end
    sat = 1'b0;
    if (q > 4194303) begin
      q = 4194303; sat = 1'b1;
    end else if (q < -4194304) begin
      q = -4194304; sat = 1'b1;
    end
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_level = 0;
    m_last  = -1000;
    m_dout  = 0;
    m_dvo   = 1'b0;
    m_sat   = 1'b0;
  endtask

  // Advance one clock edge and update the model from the inputs present before it.
  task automatic tick();
    bit p, q, s, cs;
    int v, e, sd, sh;
    e  = cyc + 1;
    p  = s_valid && (m_level < DEPTH);
    q  = en && (m_level > 0) && (e - m_last >= GAP);
    sd = int'($signed(s_data));
    sh = int'(shift);
    cs = clear_sat;
    @(posedge clk);
    #1;
    cyc   = e;
    m_dvo = q;
    if (q) begin
      m_dout = exp_q.pop_front();
      m_last = e;
    end
    if (cs) m_sat = 1'b0;
    if (p) begin
      cond(sd, sh, v, s);
      exp_q.push_back(v);
      if (s) m_sat = 1'b1;
    end
    m_level = m_level + int'(p) - int'(q);
    if (data_valid_out) begin
      obs_val.push_back(int'($signed(data_out)));
      obs_cyc.push_back(cyc);
    end
  endtask

  task automatic drain();
    s_valid   = 1'b0;
    clear_sat = 1'b0;
    en        = 1'b1;
    for (int i = 0; i < 200 && m_level > 0; i++) tick();
    repeat (GAP + 1) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; shift = '0; en = 1'b0; clear_sat = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({data_out, data_valid_out, fifo_level, sat_flag, s_ready} !== {24'd0, 1'b0, LW'(0), 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_hold got dout=%0d dvo=%0b lvl=%0d sat=%0b rdy=%0b exp 0/0/0/0/1",
               data_out, data_valid_out, fifo_level, sat_flag, s_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if ({data_out, data_valid_out, fifo_level, sat_flag, s_ready} !== {24'd0, 1'b0, LW'(0), 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_release got dout=%0d dvo=%0b lvl=%0d sat=%0b rdy=%0b exp 0/0/0/0/1",
               data_out, data_valid_out, fifo_level, sat_flag, s_ready);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 24'(i * 100 + 7);
      shift  = 2'($urandom_range(0, 3));
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({data_out, data_valid_out, fifo_level, sat_flag, s_ready} !== {24'd0, 1'b0, LW'(0), 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid got dout=%0d dvo=%0b lvl=%0d sat=%0b rdy=%0b exp 0/0/0/0/1",
               data_out, data_valid_out, fifo_level, sat_flag, s_ready);
    end
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    obs_val.delete(); obs_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (data_valid_out !== 1'b0 || fifo_level !== LW'(0)) begin
        n_fail++;
        $display("FAIL reset_mid_idle cyc=%0d got dvo=%0b lvl=%0d exp 0/0", cyc, data_valid_out, fifo_level);
      end
    end
  endtask

  task automatic test_single();
    obs_val.delete(); obs_cyc.delete();
    en = 1'b1; shift = 2'd0; s_data = 24'd1000; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n_chk++;
    if (data_valid_out !== 1'b0 || fifo_level !== LW'(1)) begin
      n_fail++;
      $display("FAIL single_push got dvo=%0b lvl=%0d exp 0/1", data_valid_out, fifo_level);
    end
    tick();
    n_chk++;
    if (data_valid_out !== 1'b1 || data_out !== 24'd1000) begin
      n_fail++;
      $display("FAIL single_issue got dvo=%0b dout=%0d exp 1/1000", data_valid_out, data_out);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if (data_valid_out !== 1'b0 || data_out !== 24'd1000 || fifo_level !== LW'(0)) begin
        n_fail++;
        $display("FAIL single_after cyc=%0d got dvo=%0b dout=%0d lvl=%0d exp 0/1000/0",
                 cyc, data_valid_out, data_out, fifo_level);
      end
    end
  endtask

  task automatic test_rounding();
    int t_sh[6]  = '{1, 1, 2, 1, 0, 0};
    int t_in[6]  = '{3, -3, 6, -4, 8388607, -8388608};
    int t_exp[6] = '{2, -1, 2, -2, 4194303, -4194304};
    bit t_sat[6] = '{0, 0, 0, 0, 1, 1};
    obs_val.delete(); obs_cyc.delete();
    en = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      shift  = 2'(t_sh[i]);
      s_data = 24'(t_in[i]);
      tick();
      n_chk++;
      if (sat_flag !== t_sat[i] || fifo_level !== LW'(i + 1)) begin
        n_fail++;
        $display("FAIL round_push[%0d] got sat=%0b lvl=%0d exp %0b/%0d", i, sat_flag, fifo_level, t_sat[i], i + 1);
      end
    end
    s_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 6 * GAP + 4; i++) begin
      tick();
      n_chk++;
      if (data_valid_out !== m_dvo || data_out !== 24'(m_dout)) begin
        n_fail++;
        $display("FAIL round_issue cyc=%0d got dvo=%0b dout=%0d exp %0b/%0d", cyc, data_valid_out, data_out, m_dvo, m_dout);
      end
    end
    n_chk++;
    if (obs_val.size() != 6) begin
      n_fail++;
      $display("FAIL round_count got %0d exp 6", obs_val.size());
    end
    for (int i = 0; i < 6 && i < obs_val.size(); i++) begin
      n_chk++;
      if (obs_val[i] != t_exp[i]) begin
        n_fail++;
        $display("FAIL round_value[%0d] got %0d exp %0d", i, obs_val[i], t_exp[i]);
      end
    end
    clear_sat = 1'b1;
    tick();
    n_chk++;
    if (sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear got %0b exp 0", sat_flag);
    end
    shift = 2'd0; s_data = 24'd8388607; s_valid = 1'b1;
    tick();
    s_valid = 1'b0; clear_sat = 1'b0;
    n_chk++;
    if (sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_set_wins got %0b exp 1", sat_flag);
    end
    drain();
  endtask

  task automatic test_burst();
    int  next;
    bit  will_push;
    bit  saw_full;
    obs_val.delete(); obs_cyc.delete();
    next = 1; saw_full = 1'b0; en = 1'b1; shift = 2'd0;
    for (int i = 0; i < 200; i++) begin
      s_valid   = (next <= 12);
      s_data    = 24'(next);
      will_push = s_valid && (m_level < DEPTH);
      tick();
      if (will_push) next++;
      if (fifo_level == LW'(DEPTH) && s_ready == 1'b0) saw_full = 1'b1;
      n_chk++;
      if (s_ready !== (m_level < DEPTH) || fifo_level !== LW'(m_level) ||
          data_valid_out !== m_dvo || data_out !== 24'(m_dout)) begin
        n_fail++;
        $display("FAIL burst_cycle cyc=%0d got rdy=%0b lvl=%0d dvo=%0b dout=%0d exp %0b/%0d/%0b/%0d",
                 cyc, s_ready, fifo_level, data_valid_out, data_out, m_level < DEPTH, m_level, m_dvo, m_dout);
      end
      if (next > 12 && m_level == 0) break;
    end
    s_valid = 1'b0;
    repeat (GAP + 1) tick();
    n_chk++;
    if (saw_full !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_full got saw_full=%0b exp 1", saw_full);
    end
    n_chk++;
    if (obs_val.size() != 12) begin
      n_fail++;
      $display("FAIL burst_count got %0d exp 12", obs_val.size());
    end
    for (int i = 0; i < obs_val.size() && i < 12; i++) begin
      n_chk++;
      if (obs_val[i] != i + 1 || (i > 0 && obs_cyc[i] - obs_cyc[i-1] != GAP)) begin
        n_fail++;
        $display("FAIL burst_pulse[%0d] got val=%0d gap=%0d exp val=%0d gap=%0d", i, obs_val[i],
                 (i > 0) ? obs_cyc[i] - obs_cyc[i-1] : GAP, i + 1, GAP);
      end
    end
  endtask

  task automatic test_enable();
    int  ref_v[$];
    int  v;
    bit  s;
    int  c0;
    obs_val.delete(); obs_cyc.delete();
    en = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 24'($urandom_range(0, 20000)) - 24'd10000;
      shift  = 2'($urandom_range(0, 3));
      cond(int'($signed(s_data)), int'(shift), v, s);
      ref_v.push_back(v);
      tick();
    end
    s_valid = 1'b0;
    repeat (GAP) tick();
    n_chk++;
    if (obs_val.size() != 0 || fifo_level !== LW'(3)) begin
      n_fail++;
      $display("FAIL enable_gated got pulses=%0d lvl=%0d exp 0/3", obs_val.size(), fifo_level);
    end
    en = 1'b1;
    c0 = cyc;
    repeat (3 * GAP + 2) tick();
    n_chk++;
    if (obs_val.size() != 3) begin
      n_fail++;
      $display("FAIL enable_count got %0d exp 3", obs_val.size());
    end
    for (int i = 0; i < obs_val.size() && i < 3; i++) begin
      n_chk++;
      if (obs_val[i] != ref_v[i] || obs_cyc[i] != c0 + 1 + i * GAP) begin
        n_fail++;
        $display("FAIL enable_pulse[%0d] got val=%0d cyc=%0d exp val=%0d cyc=%0d",
                 i, obs_val[i], obs_cyc[i], ref_v[i], c0 + 1 + i * GAP);
      end
    end
  endtask

  task automatic test_wrap();
    int  ref_v[$];
    int  pushes;
    int  v;
    bit  s;
    bit  will_push;
    bit  done;
    obs_val.delete(); obs_cyc.delete();
    pushes = 0; done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      s_valid   = (pushes < 20) && ($urandom_range(0, 2) != 0);
      s_data    = ($urandom_range(0, 3) == 0) ? 24'($urandom()) : 24'($urandom_range(0, 4000000));
      shift     = 2'($urandom_range(0, 3));
      en        = ($urandom_range(0, 4) != 0);
      clear_sat = ($urandom_range(0, 7) == 0);
      will_push = s_valid && (m_level < DEPTH);
      if (will_push) begin
        cond(int'($signed(s_data)), int'(shift), v, s);
        ref_v.push_back(v);
      end
      tick();
      if (will_push) pushes++;
      n_chk++;
      if (fifo_level !== LW'(m_level) || fifo_level > LW'(DEPTH) || s_ready !== (m_level < DEPTH) ||
          data_valid_out !== m_dvo || data_out !== 24'(m_dout) || sat_flag !== m_sat) begin
        n_fail++;
        $display("FAIL wrap_cycle cyc=%0d got lvl=%0d rdy=%0b dvo=%0b dout=%0d sat=%0b exp %0d/%0b/%0b/%0d/%0b",
                 cyc, fifo_level, s_ready, data_valid_out, data_out, sat_flag,
                 m_level, m_level < DEPTH, m_dvo, m_dout, m_sat);
      end
      if (pushes == 20 && m_level == 0) begin
        done = 1'b1;
        break;
      end
    end
    s_valid = 1'b0; clear_sat = 1'b0; en = 1'b1;
    repeat (GAP + 1) tick();
    n_chk++;
    if (!done || obs_val.size() != 20) begin
      n_fail++;
      $display("FAIL wrap_complete got done=%0b pulses=%0d exp 1/20", done, obs_val.size());
    end
    for (int i = 0; i < obs_val.size() && i < ref_v.size(); i++) begin
      n_chk++;
      if (obs_val[i] != ref_v[i]) begin
        n_fail++;
        $display("FAIL wrap_order[%0d] got %0d exp %0d", i, obs_val[i], ref_v[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_rounding();
    test_burst();
    test_enable();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/opti_in_stage.md
# opti_in_stage

Input conditioning and pacing stage directly upstream of the second-order-section (SOS) filter stage. It accepts 24-bit signed samples over a valid/ready handshake and buffers them in a small FIFO. Each sample gets a programmable headroom shift with rounding, then saturates to the SOS working range of ±2^22. Samples are issued to the SOS `data_in`/`data_valid_in` as single-cycle pulses spaced at least `ISSUE_GAP` cycles apart, so the SOS multiplier pipeline is never overrun.

## Interface
Parameters:
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `ISSUE_GAP`, 4, minimum cycles between consecutive `data_valid_out` pulses; ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_data`  in  24  signed input sample.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  stage can accept; equals !full (combinational from count).
- `shift`  in  2  arithmetic right shift 0..3, sampled at push.
- `en`  in  1  issue enable; FIFO still accepts when low.
- `clear_sat`  in  1  clears `sat_flag`.
- `data_out`  out  24  signed conditioned sample to SOS `data_in`.
- `data_valid_out`  out  1  single-cycle issue strobe to SOS `data_valid_in`.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `sat_flag`  out  1  sticky saturation indicator.

## Operation
- Push occurs when `s_valid && s_ready`. The conditioned value is written at the tail.
- Conditioning uses a 25-bit signed intermediate:
  - shift=0: t = s_data.
  - shift>0: t = (s_data + 2^(shift-1)) >>> shift, which is round-half-up.
  - Saturate t to [-4194304, 4194303].
  - Any clamp sets `sat_flag` at that edge.
- `sat_flag`: `clear_sat` clears it. If a saturation occurs in the same cycle as `clear_sat`, set wins.
- Issue counter `gap_cnt` (0..ISSUE_GAP-1):
  - Issue happens when `en && !empty && gap_cnt==0`.
  - On issue: pop the head, register it to `data_out`, assert `data_valid_out` for exactly one cycle, and load `gap_cnt` = ISSUE_GAP-1.
  - Otherwise `gap_cnt` decrements toward 0. It keeps decrementing while `en` is low.
- `data_out` holds the last issued value between pulses.
- Simultaneous push and pop: `fifo_level` is unchanged and both occur.
- Full: `s_ready`=0 and no push. Empty: no issue. There is no FIFO bypass; a pushed sample is poppable from the next cycle.
- Read and write pointers wrap modulo DEPTH. Order is strictly FIFO.
- Changing `shift` mid-stream affects only later pushes.

## Timing
- Reset values:
  - `data_out`=0, `data_valid_out`=0, `fifo_level`=0, `sat_flag`=0, `gap_cnt`=0.
  - Pointers are 0, so `s_ready`=1 while in reset and after it.
- Latency: a sample pushed at edge k into an empty FIFO, with `en`=1 and `gap_cnt`=0, appears with `data_valid_out`=1 after edge k+1.
- Pacing: with the FIFO continuously non-empty and `en`=1, pulses occur every ISSUE_GAP cycles exactly. ISSUE_GAP=1 gives back-to-back pulses.
- `en` low: no pulse. The pulse resumes at the first edge with `en`=1 and `gap_cnt`=0.
- Reset mid-operation: all buffered samples are dropped. No `data_valid_out` until new pushes arrive.
- `fifo_level` updates at the same edge as the push/pop that caused it.

## Test plan
- Reset: hold `rst_n`=0 mid-burst, release → all outputs 0, `s_ready`=1, `fifo_level`=0, and no pulse until the next push.
- Single sample: shift=0, `s_data`=1000 pushed at edge k → `data_out`=1000 with `data_valid_out`=1 for one cycle after edge k+1, then no further pulses.
- Rounding/saturation:
  - shift=1: 3→2, -3→-1.
  - shift=2: 6→2.
  - shift=0: 8388607→4194303 with `sat_flag`=1, and -8388608→-4194304.
  - `clear_sat` together with a saturating push → `sat_flag` stays 1.
- Burst: DEPTH=8, ISSUE_GAP=4, 12 samples 1..12 with `s_valid` held high:
  - `s_ready` drops when `fifo_level`=8.
  - Pulses are exactly 4 cycles apart.
  - Outputs are 1..12 in order, with none lost or duplicated.
- Enable gating: fill 3 samples with `en`=0 → no pulses and `fifo_level`=3. Raise `en` → first pulse next edge, then 3 pulses spaced ISSUE_GAP apart.
- Pointer wrap: 20 samples with random `s_valid` gaps and concurrent push/pop → output order matches a reference queue, and `fifo_level` never exceeds 8.
